sum_to_stream: RTL



---
 rtl/sum_to_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sum_to_stream.sv
// Pulse-density serialiser: turns a target ones-count N into a T-bit frame with N evenly spread ones,
// emitted as SAMPLES chunks of OSF bits with valid/ready handshaking on both load and chunk sides.
module sum_to_stream #(
    parameter  int SAMPLES = 128,
    parameter  int OSF     = 8,
    localparam int T       = SAMPLES * OSF,
    localparam int CW      = $clog2(T) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CW-1:0] Count_In,
    input  logic          Load_Valid,
    output logic          Load_Ready,
    output logic [OSF-1:0] Chunk_Out,
    output logic          Chunk_Valid,
    input  logic          Chunk_Ready,
    output logic          Chunk_Last,
    output logic          Sat_Err
);

    localparam int AW = CW + 1;
    localparam int IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    localparam logic [CW-1:0] T_CW     = CW'(T);
    localparam logic [AW-1:0] T_AW     = AW'(T);
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]  n_reg;
    logic [AW-1:0]  acc;
    logic [IW-1:0]  idx;
    logic           sat_err_reg;

    logic           load_ready;
    logic           chunk_valid;
    logic           last_idx;
    logic           load_fire;
    logic           chunk_fire;

    logic [OSF-1:0] chunk_bits;
    logic [AW-1:0]  acc_nxt;
    logic [AW-1:0]  acc_walk;
    logic [AW-1:0]  acc_sum;

    // Error-feedback chain: each bit adds N, emits a one and subtracts T whenever the running sum reaches T.
    always_comb begin
        // NOTE: blocking assignments here are intentional; each stage must see the value the previous stage just computed.
        acc_walk   = acc;
        acc_sum    = '0;
        chunk_bits = '0;
        for (int j = 0; j < OSF; j++) begin
            acc_sum       = acc_walk + AW'(n_reg);
            chunk_bits[j] = (acc_sum >= T_AW);
            acc_walk      = chunk_bits[j] ? (acc_sum - T_AW) : acc_sum;
        end
        acc_nxt = acc_walk;
    end

    assign last_idx   = (idx == LAST_IDX);
    assign load_fire  = (state == IDLE) && Load_Valid;
    assign chunk_fire = (state == RUN) && Chunk_Ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking for every registered value so all flops update from the same pre-edge view.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        load_ready  = 1'b0;
        chunk_valid = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (Load_Valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                chunk_valid = 1'b1;
                if (Chunk_Ready && last_idx) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_reg       <= '0;
            acc         <= '0;
            idx         <= '0;
            sat_err_reg <= 1'b0;
        end else if (load_fire) begin
            n_reg       <= (Count_In > T_CW) ? T_CW : Count_In;
            sat_err_reg <= (Count_In > T_CW);
            acc         <= '0;
            idx         <= '0;
        end else if (chunk_fire) begin
            if (last_idx) begin
                acc <= '0;
                idx <= '0;
            end else begin
                acc <= acc_nxt;
                idx <= idx + 1'b1;
            end
        end
    end

    // Chunk outputs depend only on registers, so they stay put while the sink stalls.
    assign Load_Ready  = load_ready;
    assign Chunk_Valid = chunk_valid;
    assign Chunk_Out   = chunk_valid ? chunk_bits : '0;
    assign Chunk_Last  = chunk_valid && last_idx;
    assign Sat_Err     = sat_err_reg;

endmodule
